// File: rtl/hack_pkg.sv
`default_nettype none
//============================================================================
// Module : hack_pkg
// Brief  : Shared Hack word/RAM8 sizing constants and the RAM8 clear-FSM
//          state encoding.
// Rev    : 1.0  initial release
//============================================================================
package hack_pkg;

   localparam int HACK_WORD_W = 16;
   localparam int RAM8_DEPTH  = 8;
   localparam int RAM8_ADDR_W = 3;

   // Bulk-clear sequencer states
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage : hack_pkg
`default_nettype wire

// File: rtl/dmux8way.sv
`default_nettype none
//============================================================================
// Module : dmux8way
// Brief  : 1-to-8 demultiplexer; the output selected by sel follows in,
//          the other seven are held low.
// Rev    : 1.0  initial release
//============================================================================
module dmux8way (
   input  logic       in,
   input  logic [2:0] sel,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic       e,
   output logic       f,
   output logic       g,
   output logic       h
);

   // Route in to the single output chosen by sel
   always_comb begin
      a = 1'b0;
      b = 1'b0;
      c = 1'b0;
      d = 1'b0;
      e = 1'b0;
      f = 1'b0;
      g = 1'b0;
      h = 1'b0;
      case (sel)
         3'd0:    a = in;
         3'd1:    b = in;
         3'd2:    c = in;
         3'd3:    d = in;
         3'd4:    e = in;
         3'd5:    f = in;
         3'd6:    g = in;
         default: h = in;
      endcase
   end

endmodule : dmux8way
`default_nettype wire

// File: rtl/mux8way16.sv
`default_nettype none
//============================================================================
// Module : mux8way16
// Brief  : 8-to-1 word multiplexer; y returns the input chosen by sel.
// Rev    : 1.0  initial release
//============================================================================
module mux8way16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] y
);

   // Select one of the eight words
   always_comb begin
      y = a;
      case (sel)
         3'd0:    y = a;
         3'd1:    y = b;
         3'd2:    y = c;
         3'd3:    y = d;
         3'd4:    y = e;
         3'd5:    y = f;
         3'd6:    y = g;
         default: y = h;
      endcase
   end

endmodule : mux8way16
`default_nettype wire

// File: rtl/ram8_dmux16.sv
`default_nettype none
//============================================================================
// Module : ram8_dmux16
// Brief  : 8 x 16-bit Hack RAM bank. Writes are steered by a dmux8way load
//          decoder, reads come back through mux8way16, and a clear request
//          zeroes the eight words one per cycle while busy is high.
// Rev    : 1.0  initial release
//============================================================================
module ram8_dmux16
   import hack_pkg::*;
#(
   parameter int WIDTH = HACK_WORD_W,
   parameter int DEPTH = RAM8_DEPTH      // only 8 is supported
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in,
   input  logic [RAM8_ADDR_W-1:0] address,
   input  logic                   load,
   input  logic                   clear,
   output logic [WIDTH-1:0]       out,
   output logic                   busy
);

   localparam logic [RAM8_ADDR_W-1:0] c_last_word = RAM8_ADDR_W'(DEPTH - 1);

   logic [0:0]             r_state;
   logic [0:0]             w_state_nxt;
   logic [RAM8_ADDR_W-1:0] r_cnt;
   logic [RAM8_ADDR_W-1:0] w_cnt_nxt;

   logic                   w_wr_req;
   logic [DEPTH-1:0]       w_wr_en;
   logic [DEPTH-1:0]       w_clr_en;
   logic [WIDTH-1:0]       r_mem [DEPTH];

   // Clear-sequencer state and word counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state: a clear in IDLE starts the sweep; the sweep ends after the
   // last word, and further clear requests while sweeping are ignored
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (clear) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         ST_CLEAR: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_last_word) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // busy decodes directly from the state flop, so it is glitch-free
   always_comb begin
      busy = (r_state == ST_CLEAR);
   end

   // Loads arriving during a sweep are dropped, not queued
   assign w_wr_req = load & ~busy;

   dmux8way u_wr_dmux (
      .in  (w_wr_req),
      .sel (address),
      .a   (w_wr_en[0]),
      .b   (w_wr_en[1]),
      .c   (w_wr_en[2]),
      .d   (w_wr_en[3]),
      .e   (w_wr_en[4]),
      .f   (w_wr_en[5]),
      .g   (w_wr_en[6]),
      .h   (w_wr_en[7])
   );

   // Sweep pointer picks the word zeroed on each busy cycle
   dmux8way u_clr_dmux (
      .in  (busy),
      .sel (r_cnt),
      .a   (w_clr_en[0]),
      .b   (w_clr_en[1]),
      .c   (w_clr_en[2]),
      .d   (w_clr_en[3]),
      .e   (w_clr_en[4]),
      .f   (w_clr_en[5]),
      .g   (w_clr_en[6]),
      .h   (w_clr_en[7])
   );

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         // One storage word; write and zero strobes are never both active
         always_ff @(posedge clk) begin
            if (reset) begin
               r_mem[gi] <= '0;
            end else if (w_clr_en[gi]) begin
               r_mem[gi] <= '0;
            end else if (w_wr_en[gi]) begin
               r_mem[gi] <= in;
            end
         end
      end
   endgenerate

   // Combinational read; no write bypass, so new data appears a cycle later
   mux8way16 #(
      .WIDTH (WIDTH)
   ) u_rd_mux (
      .a   (r_mem[0]),
      .b   (r_mem[1]),
      .c   (r_mem[2]),
      .d   (r_mem[3]),
      .e   (r_mem[4]),
      .f   (r_mem[5]),
      .g   (r_mem[6]),
      .h   (r_mem[7]),
      .sel (address),
      .y   (out)
   );

endmodule : ram8_dmux16
`default_nettype wire

// File: tb/tb_ram8_dmux16.sv
`default_nettype none
//============================================================================
// Module : tb_ram8_dmux16
// Brief  : Self-checking bench for ram8_dmux16 against a word-array model
//          with a remaining-clear-cycles count.
// Rev    : 1.0  initial release
//============================================================================
module tb_ram8_dmux16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] in_d = '0;
   logic [2:0]  address = '0;
   logic        load = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] out;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the words, plus how many sweep edges are still to come
   logic [15:0] m_mem [8];
   int          m_left = 0;

   always #5 clk = ~clk;

   ram8_dmux16 dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in_d),
      .address (address),
      .load    (load),
      .clear   (clear),
      .out     (out),
      .busy    (busy)
   );

   // One clock edge: update the model from the inputs held across the edge,
   // then move 1 ns past the edge so outputs are settled for sampling
   task automatic step();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
         m_left = 0;
      end else if (m_left > 0) begin
         m_mem[8 - m_left] = 16'h0000;
         m_left--;
      end else begin
         if (load) m_mem[address] = in_d;
         if (clear) m_left = 8;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b1; clear = 1'b1;
      in_d = 16'($urandom); address = 3'($urandom);
      step();
      reset = 1'b0; load = 1'b0; clear = 1'b0;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         n_tests++;
         if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_word[%0d]: out=%h expected=0000", a, out);
         end
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: busy=%b expected=0", busy);
      end
   endtask

   task automatic test_walk();
      for (int k = 0; k < 8; k++) begin
         address = 3'(k); in_d = 16'h0001 << k; load = 1'b1;
         step();
         load = 1'b0;
         if (k == 4) begin
            address = 3'd0;
            #1;
            n_tests++;
            if (out !== 16'h0001) begin
               n_fail++;
               $display("FAIL walk_reread0: out=%h expected=0001", out);
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         address = 3'(k);
         #1;
         n_tests++;
         if (out !== (16'h0001 << k) || out !== m_mem[k]) begin
            n_fail++;
            $display("FAIL walk_word[%0d]: out=%h expected=%h", k, out, 16'h0001 << k);
         end
      end
   endtask

   task automatic test_latency();
      address = 3'd3; in_d = 16'hBEEF; load = 1'b1;
      #1;
      n_tests++;
      if (out !== 16'h0008) begin
         n_fail++;
         $display("FAIL latency_before: out=%h expected=0008", out);
      end
      step();
      load = 1'b0;
      n_tests++;
      if (out !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL latency_after: out=%h expected=beef", out);
      end
   endtask

   task automatic test_clear_sweep();
      int nbusy;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a); in_d = 16'hFFFF; load = 1'b1;
         step();
      end
      load = 1'b0; address = 3'd5; clear = 1'b1;
      step();
      clear = 1'b0;
      nbusy = (busy === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_tests++;
         if (out !== ((i < 6) ? 16'hFFFF : 16'h0000) || out !== m_mem[5]) begin
            n_fail++;
            $display("FAIL sweep_word5_edge%0d: out=%h expected=%h", i, out,
                     (i < 6) ? 16'hFFFF : 16'h0000);
         end
         if (busy === 1'b1) nbusy++;
      end
      n_tests++;
      if (nbusy != 8 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL sweep_busy_len: cycles=%0d busy_end=%b expected=8/0", nbusy, busy);
      end
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         n_tests++;
         if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL sweep_zero[%0d]: out=%h expected=0000", a, out);
         end
      end
   endtask

   task automatic test_busy_collisions();
      int nbusy;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a); in_d = 16'($urandom) | 16'h0100; load = 1'b1;
         step();
      end
      load = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      nbusy = 1;
      step();
      nbusy++;
      address = 3'd2; in_d = 16'h1234; load = 1'b1; clear = 1'b1;
      step();
      nbusy++;
      load = 1'b0; clear = 1'b0;
      for (int i = 0; i < 12 && busy === 1'b1; i++) begin
         step();
         if (busy === 1'b1) nbusy++;
      end
      n_tests++;
      if (nbusy != 8 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_busy_len: cycles=%0d busy=%b expected=8/0", nbusy, busy);
      end
      address = 3'd2;
      #1;
      n_tests++;
      if (out !== 16'h0000) begin
         n_fail++;
         $display("FAIL collide_word2: out=%h expected=0000", out);
      end
      // load and clear together at an idle edge: write lands, then is swept
      address = 3'd6; in_d = 16'h5A5A; load = 1'b1; clear = 1'b1;
      step();
      load = 1'b0; clear = 1'b0;
      n_tests++;
      if (out !== 16'h5A5A || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL loadclear_write: out=%h busy=%b expected=5a5a/1", out, busy);
      end
      for (int i = 0; i < 8; i++) step();
      n_tests++;
      if (out !== 16'h0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL loadclear_swept: out=%h busy=%b expected=0000/0", out, busy);
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int a = 0; a < 8; a++) begin
         address = 3'(a); in_d = 16'hC0DE ^ 16'(a); load = 1'b1;
         step();
      end
      load = 1'b0; clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_busy: busy=%b expected=0", busy);
      end
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         n_tests++;
         if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL midreset_word[%0d]: out=%h expected=0000", a, out);
         end
      end
      address = 3'd7; in_d = 16'h00AA; load = 1'b1;
      step();
      load = 1'b0;
      n_tests++;
      if (out !== 16'h00AA) begin
         n_fail++;
         $display("FAIL midreset_load7: out=%h expected=00aa", out);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset   = ($urandom_range(0, 59) == 0);
         load    = 1'($urandom);
         clear   = ($urandom_range(0, 11) == 0);
         address = 3'($urandom);
         in_d    = 16'($urandom);
         step();
         n_tests++;
         if (out !== m_mem[address] || busy !== (m_left > 0)) begin
            n_fail++;
            $display("FAIL random_cycle%0d: out=%h busy=%b expected=%h/%b", n, out, busy,
                     m_mem[address], m_left > 0);
         end
         address = 3'($urandom);
         #1;
         n_tests++;
         if (out !== m_mem[address]) begin
            n_fail++;
            $display("FAIL random_read%0d: addr=%0d out=%h expected=%h", n, address, out,
                     m_mem[address]);
         end
      end
      reset = 1'b0; load = 1'b0; clear = 1'b0;
   endtask

   initial begin
      test_reset();
      test_walk();
      test_latency();
      test_clear_sweep();
      test_busy_collisions();
      test_reset_mid_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule : tb_ram8_dmux16
`default_nettype wire
